// File: rtl/ethernet_rx_fetch_pkg.sv
// Shared types and DM9000 register constants for the Ethernet RX fetch master.
package ethernet_rx_fetch_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PEEK_IDX,
    S_PEEK_RD0,
    S_PEEK_RD1,
    S_ISR_IDX,
    S_ISR_WR,
    S_RX_IDX,
    S_RD_STATUS,
    S_RD_LEN,
    S_RD_DATA,
    S_HALT
  } RxFetchState_t;

  localparam logic [7:0] DM9000_MRCMDX = 8'hF0;
  localparam logic [7:0] DM9000_MRCMD  = 8'hF2;
  localparam logic [7:0] DM9000_ISR    = 8'hFE;

  localparam logic [7:0] STATUS_ERR_MASK = 8'hBF;
  localparam logic [7:0] RDY_EMPTY       = 8'h00;
  localparam logic [7:0] RDY_PKT         = 8'h01;

  localparam logic ADDR_INDEX = 1'b0;
  localparam logic ADDR_DATA  = 1'b1;

endpackage

// File: rtl/ethernet_rx_fetch_bus_xfer.sv
// Single-outstanding bus transfer: holds the request until the controller's
// stall goes high then low, captures rdata in that completion cycle.
module eth_bus_xfer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_write,
  input  logic        i_addr,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_bus_rdata,
  input  logic        i_bus_stall,
  output logic        o_bus_read,
  output logic        o_bus_write,
  output logic        o_bus_addr,
  output logic [15:0] o_bus_wdata,
  output logic        o_done,
  output logic [15:0] o_rdata
);

  logic        r_read;
  logic        r_write;
  logic        r_addr;
  logic [15:0] r_wdata;
  logic        r_seen_stall;
  logic        r_done;
  logic [15:0] r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= 1'b0;
      r_wdata      <= '0;
      r_seen_stall <= 1'b0;
      r_done       <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_read || r_write) begin
        if (i_bus_stall) begin
          r_seen_stall <= 1'b1;
        end else if (r_seen_stall) begin
          r_read       <= 1'b0;
          r_write      <= 1'b0;
          r_seen_stall <= 1'b0;
          r_done       <= 1'b1;
          r_rdata      <= i_bus_rdata;
        end
      end else if (i_start) begin
        r_read  <= !i_write;
        r_write <= i_write;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
    end
  end

  assign o_bus_read  = r_read;
  assign o_bus_write = r_write;
  assign o_bus_addr  = r_addr;
  assign o_bus_wdata = r_wdata;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;

endmodule

// File: rtl/ethernet_rx_fetch.sv
// DM9000 RX frame fetch master: peeks the ready byte, reads status/len/data and
// streams 16-bit words out. Define ETH_RX_CRC_STRIP_EN to drop the trailing CRC.
module ethernet_rx_fetch
  import ethernet_rx_fetch_pkg::*;
#(
  parameter int unsigned MAX_FRAME_BYTES = 1536,
  parameter logic [7:0]  REG_MRCMDX      = DM9000_MRCMDX,
  parameter logic [7:0]  REG_MRCMD       = DM9000_MRCMD,
  parameter logic [7:0]  REG_ISR         = DM9000_ISR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq,
  output logic        bus_read,
  output logic        bus_write,
  output logic        bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  input  logic        bus_stall,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        out_err,
  output logic [15:0] out_len,
  output logic        rx_fatal
);

  RxFetchState_t r_state;
  logic          r_issued;
  logic          r_start;
  logic          r_wr;
  logic          r_addr;
  logic [15:0]   r_wdata;
  logic [7:0]    r_status;
  logic [15:0]   r_frame_len;
  logic [15:0]   r_words_left;
  logic [15:0]   r_fwd_left;
  logic          r_drop;
  logic [15:0]   r_out_data;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_out_err;
  logic [15:0]   r_out_len;
  logic          r_fatal;

  logic          w_done;
  logic [15:0]   w_rdata;
  logic          w_req_en;
  logic          w_req_wr;
  logic          w_req_addr;
  logic [15:0]   w_req_wdata;
  logic [15:0]   w_words;
  logic [15:0]   w_fwd;
  logic [15:0]   w_len_out;
  logic          w_short;
  logic          w_drop;

  eth_bus_xfer u_xfer (
    .clk         (clk),
    .rst         (rst),
    .i_start     (r_start),
    .i_write     (r_wr),
    .i_addr      (r_addr),
    .i_wdata     (r_wdata),
    .i_bus_rdata (bus_rdata),
    .i_bus_stall (bus_stall),
    .o_bus_read  (bus_read),
    .o_bus_write (bus_write),
    .o_bus_addr  (bus_addr),
    .o_bus_wdata (bus_wdata),
    .o_done      (w_done),
    .o_rdata     (w_rdata)
  );

  // Length decode happens on the RD_LEN completion word (w_rdata); 17-bit sum avoids wrap.
  assign w_words = 16'(({1'b0, w_rdata} + 17'd1) >> 1);
`ifdef ETH_RX_CRC_STRIP_EN
  assign w_short   = (w_rdata < 16'd4);
  assign w_len_out = w_rdata - 16'd4;
  assign w_fwd     = 16'(({1'b0, w_len_out} + 17'd1) >> 1);
`else
  assign w_short   = (w_rdata == 16'd0);
  assign w_len_out = w_rdata;
  assign w_fwd     = w_words;
`endif
  assign w_drop = (w_rdata > 16'(MAX_FRAME_BYTES)) || w_short;

  always_comb begin
    w_req_en    = 1'b1;
    w_req_wr    = 1'b0;
    w_req_addr  = ADDR_DATA;
    w_req_wdata = '0;
    case (r_state)
      S_IDLE, S_HALT: w_req_en = 1'b0;
      S_PEEK_IDX: begin w_req_wr = 1'b1; w_req_addr = ADDR_INDEX; w_req_wdata = {8'h00, REG_MRCMDX}; end
      S_ISR_IDX:  begin w_req_wr = 1'b1; w_req_addr = ADDR_INDEX; w_req_wdata = {8'h00, REG_ISR}; end
      S_ISR_WR:   begin w_req_wr = 1'b1; w_req_wdata = 16'h0001; end
      S_RX_IDX:   begin w_req_wr = 1'b1; w_req_addr = ADDR_INDEX; w_req_wdata = {8'h00, REG_MRCMD}; end
      S_RD_DATA:  w_req_en = !r_out_valid || out_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_issued     <= 1'b0;
      r_start      <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= 1'b0;
      r_wdata      <= '0;
      r_status     <= '0;
      r_frame_len  <= '0;
      r_words_left <= '0;
      r_fwd_left   <= '0;
      r_drop       <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_len    <= '0;
      r_fatal      <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      if (w_req_en && !r_issued) begin
        r_start  <= 1'b1;
        r_issued <= 1'b1;
        r_wr     <= w_req_wr;
        r_addr   <= w_req_addr;
        r_wdata  <= w_req_wdata;
      end else if (w_done) begin
        r_issued <= 1'b0;
      end

      case (r_state)
        S_IDLE:      if (irq) r_state <= S_PEEK_IDX;
        S_PEEK_IDX:  if (w_done) r_state <= S_PEEK_RD0;
        S_PEEK_RD0:  if (w_done) r_state <= S_PEEK_RD1;
        S_PEEK_RD1:
          if (w_done) begin
            if (w_rdata[7:0] == RDY_EMPTY)    r_state <= S_ISR_IDX;
            else if (w_rdata[7:0] == RDY_PKT) r_state <= S_RX_IDX;
            else begin
              r_fatal <= 1'b1;
              r_state <= S_HALT;
            end
          end
        S_ISR_IDX:   if (w_done) r_state <= S_ISR_WR;
        S_ISR_WR:    if (w_done) r_state <= S_IDLE;
        S_RX_IDX:    if (w_done) r_state <= S_RD_STATUS;
        S_RD_STATUS:
          if (w_done) begin
            r_status <= w_rdata[15:8];
            r_state  <= S_RD_LEN;
          end
        S_RD_LEN:
          if (w_done) begin
            r_frame_len  <= w_len_out;
            r_words_left <= w_words;
            r_fwd_left   <= w_fwd;
            r_drop       <= w_drop;
            r_state      <= (w_rdata == 16'd0) ? S_PEEK_IDX : S_RD_DATA;
          end
        S_RD_DATA:
          if (w_done) begin
            r_words_left <= r_words_left - 16'd1;
            // Words past the forward count (CRC) or of a dropped frame are read and discarded.
            if (!r_drop && r_fwd_left != 16'd0) begin
              r_fwd_left  <= r_fwd_left - 16'd1;
              r_out_data  <= w_rdata;
              r_out_valid <= 1'b1;
              r_out_last  <= (r_fwd_left == 16'd1);
              r_out_err   <= (r_fwd_left == 16'd1) && ((r_status & STATUS_ERR_MASK) != 8'h00);
              r_out_len   <= r_frame_len;
            end
            if (r_words_left == 16'd1) r_state <= S_PEEK_IDX;
          end
        default:     r_state <= S_HALT;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_err   = r_out_err;
  assign out_len   = r_out_len;
  assign rx_fatal  = r_fatal;

endmodule

// File: tb/tb_ethernet_rx_fetch.sv
// Scoreboard bench for ethernet_rx_fetch: a DM9000 slave model checks bus requests,
// an output monitor checks streamed words against queued expectations.
module tb_ethernet_rx_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq;
  logic        bus_read;
  logic        bus_write;
  logic        bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_stall;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_err;
  logic [15:0] out_len;
  logic        rx_fatal;

  always #5 clk = ~clk;

  ethernet_rx_fetch #(.MAX_FRAME_BYTES(1536)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .bus_read  (bus_read),
    .bus_write (bus_write),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_stall (bus_stall),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_err   (out_err),
    .out_len   (out_len),
    .rx_fatal  (rx_fatal)
  );

  typedef struct packed { logic wr; logic addr; logic [15:0] data; } bus_t;
  typedef struct packed { logic [15:0] data; logic last; logic err; logic [15:0] len; } out_t;

  bus_t exp_bus[$];
  out_t exp_out[$];
  int   checks    = 0;
  int   errors    = 0;
  int   bus_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic exp_wr(input logic a, input logic [15:0] d);
    exp_bus.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic exp_rd(input logic [15:0] resp);
    exp_bus.push_back('{wr: 1'b0, addr: 1'b1, data: resp});
  endtask

  task automatic exp_word(input logic [15:0] d, input logic l, input logic e, input logic [15:0] n);
    exp_out.push_back('{data: d, last: l, err: e, len: n});
  endtask

  task automatic push_peek(input logic [15:0] rdy);
    exp_wr(1'b0, 16'h00F0);
    exp_rd(16'hDEAD);
    exp_rd(rdy);
  endtask

  task automatic push_isr();
    exp_wr(1'b0, 16'h00FE);
    exp_wr(1'b1, 16'h0001);
  endtask

  task automatic push_hdr(input logic [15:0] status, input logic [15:0] len);
    exp_wr(1'b0, 16'h00F2);
    exp_rd(status);
    exp_rd(len);
  endtask

  task automatic pulse_irq();
    @(posedge clk); #1 irq = 1'b1;
    @(posedge clk); #1 irq = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && (exp_bus.size() != 0 || exp_out.size() != 0); i++)
      @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check({name, "_pending_bus"}, exp_bus.size(), 0);
    check({name, "_pending_out"}, exp_out.size(), 0);
  endtask

  // Slave model: stalls two cycles per request, returns queued read data.
  initial begin : slave
    bus_t e;
    bus_stall = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus_read || bus_write) begin
        bus_count++;
        e = '0;
        if (exp_bus.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: read=%0b write=%0b addr=%0b wdata=0x%0h, expected no request",
                   bus_read, bus_write, bus_addr, bus_wdata);
        end else begin
          e = exp_bus.pop_front();
          check("bus_kind", {30'd0, bus_read, bus_write}, e.wr ? 32'd1 : 32'd2);
          check("bus_addr", {31'd0, bus_addr}, {31'd0, e.addr});
          if (e.wr) check("bus_wdata", {16'd0, bus_wdata}, {16'd0, e.data});
        end
        bus_stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus_stall = 1'b0;
        bus_rdata = e.wr ? 16'h0000 : e.data;
        @(posedge clk); #1;
        bus_rdata = 16'h0000;
      end
    end
  end

  initial begin : out_monitor
    out_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: data=0x%0h last=%0b, expected no word", out_data, out_last);
        end else begin
          e = exp_out.pop_front();
          check("out_data", {16'd0, out_data}, {16'd0, e.data});
          check("out_last", {31'd0, out_last}, {31'd0, e.last});
          check("out_err",  {31'd0, out_err},  {31'd0, e.err});
          check("out_len",  {16'd0, out_len},  {16'd0, e.len});
        end
      end
    end
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    irq = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_read",  {31'd0, bus_read}, 0);
    check("rst_bus_write", {31'd0, bus_write}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_last",  {31'd0, out_last}, 0);
    check("rst_out_err",   {31'd0, out_err}, 0);
    check("rst_out_data",  {16'd0, out_data}, 0);
    check("rst_out_len",   {16'd0, out_len}, 0);
    check("rst_rx_fatal",  {31'd0, rx_fatal}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // No packet: peek, clear ISR, back to idle.
    push_peek(16'h0000);
    push_isr();
    pulse_irq();
    wait_drain("empty", 500);
    check("empty_idle_rd", {31'd0, bus_read}, 0);

    // Six-byte frame, three words.
    push_peek(16'h0001);
    push_hdr(16'h0000, 16'd6);
    exp_rd(16'h1122); exp_rd(16'h3344); exp_rd(16'h5566);
`ifdef ETH_RX_CRC_STRIP_EN
    exp_word(16'h1122, 1'b1, 1'b0, 16'd2);
`else
    exp_word(16'h1122, 1'b0, 1'b0, 16'd6);
    exp_word(16'h3344, 1'b0, 1'b0, 16'd6);
    exp_word(16'h5566, 1'b1, 1'b0, 16'd6);
`endif
    push_peek(16'h0000);
    push_isr();
    pulse_irq();
    wait_drain("frame6", 1000);

    // Same frame with back-pressure after the first word.
    out_ready = 1'b0;
    push_peek(16'h0001);
    push_hdr(16'h0000, 16'd6);
    exp_rd(16'h1122); exp_rd(16'h3344); exp_rd(16'h5566);
`ifdef ETH_RX_CRC_STRIP_EN
    exp_word(16'h1122, 1'b1, 1'b0, 16'd2);
`else
    exp_word(16'h1122, 1'b0, 1'b0, 16'd6);
    exp_word(16'h3344, 1'b0, 1'b0, 16'd6);
    exp_word(16'h5566, 1'b1, 1'b0, 16'd6);
`endif
    push_peek(16'h0000);
    push_isr();
    pulse_irq();
    for (int i = 0; i < 300 && !out_valid; i++) @(posedge clk);
    #1;
    check("stall_first_valid", {31'd0, out_valid}, 1);
    n = bus_count;
    repeat (10) @(posedge clk);
    #1;
    check("stall_no_read",   bus_count, n);
    check("stall_hold_data", {16'd0, out_data}, 32'h1122);
    check("stall_hold_vld",  {31'd0, out_valid}, 1);
    out_ready = 1'b1;
    wait_drain("stall", 1000);

    // Odd length with status error, then an oversize frame that is drained only.
    push_peek(16'h0001);
    push_hdr(16'h0400, 16'd3);
    exp_rd(16'hAABB); exp_rd(16'h77CC);
`ifndef ETH_RX_CRC_STRIP_EN
    exp_word(16'hAABB, 1'b0, 1'b0, 16'd3);
    exp_word(16'h77CC, 1'b1, 1'b1, 16'd3);
`endif
    push_peek(16'h0001);
    push_hdr(16'h0000, 16'd2000);
    for (int i = 0; i < 1000; i++) exp_rd(16'(i));
    push_peek(16'h0000);
    push_isr();
    pulse_irq();
    wait_drain("err_big", 20000);

`ifdef ETH_RX_CRC_STRIP_EN
    // Ten bytes with CRC: six payload bytes forwarded, CRC words discarded.
    push_peek(16'h0001);
    push_hdr(16'h0000, 16'd10);
    exp_rd(16'h0102); exp_rd(16'h0304); exp_rd(16'h0506); exp_rd(16'hC1C2); exp_rd(16'hC3C4);
    exp_word(16'h0102, 1'b0, 1'b0, 16'd6);
    exp_word(16'h0304, 1'b0, 1'b0, 16'd6);
    exp_word(16'h0506, 1'b1, 1'b0, 16'd6);
    push_peek(16'h0000);
    push_isr();
    pulse_irq();
    wait_drain("crc10", 1000);
`endif

    // Invalid ready byte halts; irq is then ignored until reset.
    push_peek(16'h0055);
    pulse_irq();
    wait_drain("fatal", 500);
    check("fatal_set", {31'd0, rx_fatal}, 1);
    irq = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    irq = 1'b0;
    check("halt_no_read",  {31'd0, bus_read}, 0);
    check("halt_no_write", {31'd0, bus_write}, 0);
    rst = 1'b1;
    #1;
    check("fatal_cleared", {31'd0, rx_fatal}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    push_peek(16'h0000);
    push_isr();
    pulse_irq();
    wait_drain("after_rst", 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
